cpu_wb_bridge: RTL and testbench

Converts the decoded CPU-side request stream (request, write-data and read-data channels) into Wishbone classic master cycles for the SoC interconnect. Sits directly downstream of the 68040 bus interface. It buffers one pending request behind the active one, queues write beats and read beats in 4-deep FIFOs, and expands line (4-beat) requests into wrapping Wishbone beats.

---
 rtl/soc_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/cpu_wb_bridge.sv | 166 ++++++++++++++++
 tb/tb_cpu_wb_bridge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared types and constants for the CPU-to-Wishbone bridge.
// Bridge states: IDLE = no burst open | WWAIT = burst open, waiting for a write beat | WR = write beat on bus | RD = read beat on bus
package soc_pkg;

    localparam logic [2:0]  LEN_SINGLE = 3'd1;
    localparam logic [2:0]  LEN_LINE   = 3'd4;
    localparam logic [31:0] ERR_DATA   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WWAIT = 2'd1,
        ST_WR    = 2'd2,
        ST_RD    = 2'd3
    } bridge_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        line;
        logic [3:0]  mask;
        logic        we;
    } req_t;

    // A line burst wraps inside its 16-byte line.
    function automatic logic [31:0] beat_addr(input logic [31:0] addr,
                                              input logic        line,
                                              input logic [1:0]  beat);
        logic [1:0] w_word;
        w_word = addr[3:2] + beat;
        return line ? {addr[31:4], w_word, 2'b00} : {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/cpu_wb_bridge.sv
// Turns decoded CPU requests plus write/read data channels into Wishbone classic
// master cycles, with one pending request slot and wrapping 4-beat line bursts.
module cpu_wb_bridge
    import soc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_len,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic        write_valid,
    input  logic [31:0] write_data,
    output logic        read_valid,
    output logic [31:0] read_data,
    input  logic        read_ack,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    bridge_state_e r_state, w_state_nxt;
    req_t          r_act, r_pnd, w_req;
    logic          r_act_valid, r_pnd_valid;
    logic [1:0]    r_beat;
    logic          r_bus_err;
    logic          w_stb, w_term, w_last, w_done, w_drop;
    logic          w_wr_ok, w_wr_push, w_wr_drop;
    logic          w_rf_full, w_rf_empty, w_wf_full, w_wf_empty;
    logic [31:0]   w_rf_rdata, w_wf_rdata;
    logic [CW-1:0] w_rf_count, w_wf_count;
    logic          w_unused_cnt;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_req  = '{addr: req_addr, line: (req_len == LEN_LINE), mask: req_mask, we: req_we};
    assign w_stb  = (r_state == ST_WR) || ((r_state == ST_RD) && !w_rf_full);
    assign w_term = w_stb && (wb_ack_i || wb_err_i);
    assign w_last = !r_act.line || (r_beat == 2'd3);
    assign w_done = w_term && w_last;
    assign w_drop = req_valid && r_act_valid && r_pnd_valid && !w_done;

    assign w_wr_ok   = (r_act_valid && r_act.we) || (req_valid && req_we && !r_act_valid);
    assign w_wr_push = write_valid && w_wr_ok && (!w_wf_full || (w_term && r_state == ST_WR));
    assign w_wr_drop = write_valid && w_wr_ok && w_wf_full && !(w_term && r_state == ST_WR);

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_act_valid <= 1'b0;
            r_pnd_valid <= 1'b0;
            r_act       <= '0;
            r_pnd       <= '0;
        end else if (w_done) begin
            if (r_pnd_valid) begin
                r_act       <= r_pnd;
                r_pnd_valid <= req_valid;
                if (req_valid) r_pnd <= w_req;
            end else begin
                r_act_valid <= req_valid;
                if (req_valid) r_act <= w_req;
            end
        end else if (req_valid) begin
            if (!r_act_valid) begin
                r_act_valid <= 1'b1;
                r_act       <= w_req;
            end else if (!r_pnd_valid) begin
                r_pnd_valid <= 1'b1;
                r_pnd       <= w_req;
            end
        end
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_beat    <= 2'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) r_beat <= 2'd0;
            else if (w_term)        r_beat <= r_beat + 2'd1;
            r_bus_err <= (w_term && wb_err_i) || w_drop || w_wr_drop;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wb_cyc_o    = 1'b0;
        wb_we_o     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_act_valid) w_state_nxt = r_act.we ? ST_WWAIT : ST_RD;
            end
            ST_WWAIT: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                if (!w_wf_empty) w_state_nxt = ST_WR;
            end
            ST_WR: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = 1'b1;
                if (w_term) w_state_nxt = w_last ? ST_IDLE : ST_WWAIT;
            end
            ST_RD: begin
                wb_cyc_o = 1'b1;
                if (w_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign wb_stb_o  = w_stb;
    assign wb_adr_o  = wb_cyc_o ? beat_addr(r_act.addr, r_act.line, r_beat) : 32'd0;
    assign wb_sel_o  = wb_cyc_o ? (r_act.line ? 4'hF : r_act.mask) : 4'h0;
    assign wb_dat_o  = (r_state == ST_WR) ? w_wf_rdata : 32'd0;
    assign bus_err_o = r_bus_err;
    assign req_ready = !r_pnd_valid;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (w_rst_n),
        .i_push  (w_term && (r_state == ST_RD)),
        .i_wdata (wb_err_i ? ERR_DATA : wb_dat_i),
        .i_pop   (read_ack),
        .o_rdata (w_rf_rdata),
        .o_full  (w_rf_full),
        .o_empty (w_rf_empty),
        .o_count (w_rf_count)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (w_rst_n),
        .i_push  (w_wr_push),
        .i_wdata (write_data),
        .i_pop   (w_term && (r_state == ST_WR)),
        .o_rdata (w_wf_rdata),
        .o_full  (w_wf_full),
        .o_empty (w_wf_empty),
        .o_count (w_wf_count)
    );

    assign read_valid   = !w_rf_empty;
    assign read_data    = w_rf_empty ? 32'd0 : w_rf_rdata;
    assign w_unused_cnt = ^{w_rf_count, w_wf_count};

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Directed bench for cpu_wb_bridge: reads, line bursts, writes, pending slot, errors, reset.
module tb_cpu_wb_bridge;
    import soc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_len;
    logic [3:0]  req_mask;
    logic [31:0] req_addr;
    logic        write_valid;
    logic [31:0] write_data;
    logic        read_valid, read_ack;
    logic [31:0] read_data;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i, bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] line_adr [4] = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
    logic [31:0] rdat     [4] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
    logic [31:0] wdat     [4] = '{32'hA1A1_0000, 32'hB2B2_1111, 32'hC3C3_2222, 32'hD4D4_3333};
    logic [31:0] wadr     [4] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
    logic [31:0] eadr     [4] = '{32'h7000, 32'h7004, 32'h7008, 32'h700C};
    logic [31:0] erd      [4] = '{32'hE000_0000, 32'hFFFF_FFFF, 32'hE000_0002, 32'hE000_0003};

    always #5 clk_i = ~clk_i;

    cpu_wb_bridge #(.FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
        .req_mask(req_mask), .req_addr(req_addr), .req_we(req_we),
        .write_valid(write_valid), .write_data(write_data),
        .read_valid(read_valid), .read_data(read_data), .read_ack(read_ack),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .bus_err_o(bus_err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_req(input logic [31:0] a, input logic [2:0] l, input logic [3:0] m, input logic we);
        req_valid = 1'b1; req_addr = a; req_len = l; req_mask = m; req_we = we;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        while (!wb_stb_o && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, " stb"}, 32'(wb_stb_o), 32'd1);
    endtask

    task automatic wb_beat(input logic [31:0] d, input logic err);
        wb_dat_i = d; wb_ack_i = !err; wb_err_i = err;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check_eq({tag, " valid"}, 32'(read_valid), 32'd1);
        check_eq({tag, " data"}, read_data, exp);
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 0; req_we = 0; req_len = 3'd0; req_mask = 4'h0; req_addr = 32'd0;
        write_valid = 0; write_data = 32'd0; read_ack = 0;
        wb_dat_i = 32'd0; wb_ack_i = 0; wb_err_i = 0;
        #12;
        check_eq("rst req_ready", 32'(req_ready), 32'd1);
        check_eq("rst read_valid", 32'(read_valid), 32'd0);
        check_eq("rst read_data", read_data, 32'd0);
        check_eq("rst ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        check_eq("rst adr", wb_adr_o, 32'd0);
        check_eq("rst sel", 32'(wb_sel_o), 32'd0);
        check_eq("rst dat", wb_dat_o, 32'd0);
        check_eq("rst bus_err", 32'(bus_err_o), 32'd0);
        rst_ni = 1'b1;
        repeat (3) tick();

        // single read, result left queued for the next test
        send_req(32'h0000_1006, LEN_SINGLE, 4'b0011, 1'b0);
        wait_stb("rd1");
        check_eq("rd1 adr", wb_adr_o, 32'h1004);
        check_eq("rd1 sel", 32'(wb_sel_o), 32'h3);
        check_eq("rd1 cyc/we", {30'd0, wb_cyc_o, wb_we_o}, 32'h2);
        tick(); tick();
        check_eq("rd1 stb held", 32'(wb_stb_o), 32'd1);
        wb_beat(32'hCAFE_BABE, 1'b0);
        check_eq("rd1 read_valid", 32'(read_valid), 32'd1);
        check_eq("rd1 read_data", read_data, 32'hCAFE_BABE);
        check_eq("rd1 cyc drop", 32'(wb_cyc_o), 32'd0);

        // line read; fifo fills after 3 beats because one entry is already queued
        send_req(32'h2008, LEN_LINE, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_stb("line");
            check_eq("line adr", wb_adr_o, line_adr[i]);
            check_eq("line sel", 32'(wb_sel_o), 32'hF);
            wb_beat(rdat[i], 1'b0);
        end
        check_eq("line full stb", 32'(wb_stb_o), 32'd0);
        check_eq("line full cyc", 32'(wb_cyc_o), 32'd1);
        tick();
        check_eq("line full stb2", 32'(wb_stb_o), 32'd0);
        pop_check("line pop0", 32'hCAFE_BABE);
        wait_stb("line resume");
        check_eq("line adr3", wb_adr_o, line_adr[3]);
        wb_beat(rdat[3], 1'b0);
        check_eq("line cyc end", 32'(wb_cyc_o), 32'd0);
        for (int i = 0; i < 4; i++) pop_check("line drain", rdat[i]);
        check_eq("line empty", 32'(read_valid), 32'd0);

        // line write with gaps between write beats
        send_req(32'h3000, LEN_LINE, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            write_valid = 1'b1; write_data = wdat[i];
            tick();
            write_valid = 1'b0;
            wait_stb("wr");
            check_eq("wr adr", wb_adr_o, wadr[i]);
            check_eq("wr dat", wb_dat_o, wdat[i]);
            check_eq("wr we/sel", {27'd0, wb_we_o, wb_sel_o}, 32'h1F);
            wb_beat(32'd0, 1'b0);
            if (i < 3) begin
                check_eq("wr gap cyc/stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'h2);
                tick();
            end else begin
                check_eq("wr end cyc", 32'(wb_cyc_o), 32'd0);
            end
        end

        // pending slot and dropped third request
        send_req(32'h4000, LEN_SINGLE, 4'hF, 1'b1);
        send_req(32'h5000, LEN_SINGLE, 4'hC, 1'b0);
        check_eq("pend ready", 32'(req_ready), 32'd0);
        send_req(32'h6000, LEN_SINGLE, 4'hF, 1'b0);
        check_eq("drop bus_err", 32'(bus_err_o), 32'd1);
        tick();
        check_eq("drop bus_err off", 32'(bus_err_o), 32'd0);
        write_valid = 1'b1; write_data = 32'h5555_AAAA;
        tick();
        write_valid = 1'b0;
        wait_stb("pw");
        check_eq("pw adr", wb_adr_o, 32'h4000);
        check_eq("pw dat", wb_dat_o, 32'h5555_AAAA);
        repeat (3) tick();
        check_eq("pw slow ready", 32'(req_ready), 32'd0);
        wb_beat(32'd0, 1'b0);
        check_eq("pw done ready", 32'(req_ready), 32'd1);
        wait_stb("pr");
        check_eq("pr adr", wb_adr_o, 32'h5000);
        check_eq("pr sel/we", {27'd0, wb_we_o, wb_sel_o}, 32'hC);
        wb_beat(32'h1234_5678, 1'b0);
        pop_check("pr data", 32'h1234_5678);
        repeat (3) tick();
        check_eq("dropped not issued", 32'(wb_cyc_o), 32'd0);

        // error on second beat of a line read
        send_req(32'h7000, LEN_LINE, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_stb("err");
            check_eq("err adr", wb_adr_o, eadr[i]);
            wb_beat(32'hE000_0000 + 32'(i), (i == 1));
            check_eq("err bus_err", 32'(bus_err_o), (i == 1) ? 32'd1 : 32'd0);
        end
        check_eq("err cyc end", 32'(wb_cyc_o), 32'd0);
        for (int i = 0; i < 4; i++) pop_check("err drain", erd[i]);

        // reset in the middle of a line read
        send_req(32'h8004, LEN_LINE, 4'h0, 1'b0);
        wait_stb("rstb");
        check_eq("rstb adr", wb_adr_o, 32'h8004);
        wb_beat(32'h0000_0011, 1'b0);
        check_eq("rstb queued", 32'(read_valid), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_eq("rstb cyc/stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check_eq("rstb read_valid", 32'(read_valid), 32'd0);
        check_eq("rstb req_ready", 32'(req_ready), 32'd1);
        tick(); tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        send_req(32'h9000, LEN_SINGLE, 4'hF, 1'b0);
        wait_stb("post");
        check_eq("post adr", wb_adr_o, 32'h9000);
        wb_beat(32'hBEEF_0001, 1'b0);
        pop_check("post data", 32'hBEEF_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
